alu_mc: RTL and testbench
=========================

// Module: alu_mc
// PURPOSE
//  Multi-cycle, parametrised ALU for the RISC datapath. Decodes the same 12-bit
//  cnt function/opcode encoding as the single-cycle ALU. Adds iterative
//  multiply/divide producing double-width / quotient+remainder results.
//  Has a valid/ready handshake on input and output, so the pipeline stalls on
//  long ops. Sits between operand fetch (rs/rt/imm) and writeback/memory address.
// PARAMETERS
//  WIDTH          32  operand/result width, >= 8
//  BITS_PER_CYCLE 1   mult/div bits retired per BUSY cycle; must divide WIDTH (1,2,4)
// PORTS
//  clk       in   1      clock, all logic on posedge
//  rst_n     in   1      reset, synchronous, active-low
//  in_valid  in   1      cnt/rs/rt/imm valid
//  in_ready  out  1      block accepts op this cycle
//  cnt       in   12     op: 32 add, 34 sub, 24 mult, 26 div, 36 and, 37 or,
//                        512 addi, 768 andi, 832 ori, 2048 lw addr, 2560 sw addr
//  rs,rt,imm in   WIDTH  operands; imm already extended upstream
//  out_valid out  1      result valid
//  out_ready in   1      consumer takes result
//  out       out  WIDTH  result / product low / quotient
//  out_hi    out  WIDTH  product high / remainder; 0 for other ops
//  err       out  1      cnt not in table
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE; out, out_hi, err, out_valid = 0.
//   Any in-flight op is aborted; reset wins over every other event.
//  Accept: in_valid & in_ready at posedge; operands and cnt are latched then.
//  in_ready = (state==IDLE) | (state==DONE & out_ready).
//  FSM:
//   IDLE -> DONE on accept of a 1-cycle op (all except 24, 26).
//   IDLE -> BUSY on accept of 24/26; iteration counter loaded with WIDTH/BITS_PER_CYCLE.
//   BUSY -> DONE when counter reaches 0.
//   DONE -> (IDLE | DONE | BUSY) when out_ready: IDLE if no accept this cycle, else per accepted op.
//  Latency (accept -> out_valid): 1 cycle for 1-cycle ops; WIDTH/BITS_PER_CYCLE+1 for mult/div.
//  DONE: out_valid=1; out/out_hi/err held stable until out_ready.
//   Back-to-back 1-cycle ops give 1 result per cycle.
//  out_valid=0 in IDLE/BUSY; outputs keep last value (don't care to consumers).
//  Arithmetic:
//   add/sub/addi/lw/sw wrap mod 2^WIDTH; and/or bitwise.
//   mult unsigned: {out_hi,out} = rs*rt (shift-add).
//   div unsigned restoring: out = rs/rt, out_hi = rs%rt.
//   div by zero: out = all ones, out_hi = rs, err=0.
//  Unknown cnt: 1-cycle path, out=0, out_hi=0, err=1. err=0 for all listed ops.
//  Operand inputs ignored while BUSY; changes after accept have no effect.
// CONFIGURATION
//  ALU_FLAGS_EN defined: extra outputs zero, carry, ovf (1 bit each), valid with out_valid.
//   zero  = (out==0) for every op.
//   add/addi/lw/sw: carry = carry-out; ovf = signed overflow.
//   sub: carry = borrow (rs<rt unsigned); ovf = signed overflow.
//   All other ops: carry=0, ovf=0. All three reset to 0.
//  ALU_FLAGS_EN undefined: ports zero/carry/ovf absent; no flag logic.
// TESTING (WIDTH=32, BITS_PER_CYCLE=1 unless stated)
//  1 cnt=32 rs=120 rt=145 -> out=265, out_hi=0, err=0, out_valid 1 cycle after accept;
//    then cnt=512 imm=320 -> 440; 768 -> 64; 832 -> 376, back-to-back 1 result/cycle.
//  2 cnt=24 rs=0xFFFFFFFF rt=2 -> out=0xFFFFFFFE, out_hi=1, out_valid exactly
//    33 cycles after accept, in_ready=0 throughout BUSY; repeat BITS_PER_CYCLE=4 -> 9 cycles.
//  3 cnt=26 rs=145 rt=12 -> out=12, out_hi=1; rt=0 -> out=0xFFFFFFFF, out_hi=145, err=0.
//  4 out_ready=0 for 5 cycles in DONE -> out/out_hi/out_valid stable, in_ready=0;
//    rst_n=0 mid-mult (cycle 10 of BUSY) -> next cycle out_valid=0, outputs 0, in_ready=1;
//    next op is correct.
//  5 cnt=0 -> out=0, err=1, latency 1; then cnt=34 rs=5 rt=5 -> out=0, err=0.
//  6 ALU_FLAGS_EN: add 0x7FFFFFFF+1 -> ovf=1, carry=0, zero=0;
//    add 0xFFFFFFFF+1 -> carry=1, zero=1; sub 3-5 -> carry=1, ovf=0.

Source files
------------

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// alu_mc : multi-cycle ALU with iterative mult/div and a valid/ready handshake.
//          Optional zero/carry/ovf flag outputs are enabled by ALU_FLAGS_EN.
// Revision: 1.0
// ============================================================================
module alu_mc #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      cnt,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [WIDTH-1:0] imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             err
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             ovf
`endif
);

  localparam int ITER = WIDTH / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [11:0] c_ADD  = 12'd32;
  localparam logic [11:0] c_SUB  = 12'd34;
  localparam logic [11:0] c_MULT = 12'd24;
  localparam logic [11:0] c_DIV  = 12'd26;
  localparam logic [11:0] c_AND  = 12'd36;
  localparam logic [11:0] c_OR   = 12'd37;
  localparam logic [11:0] c_ADDI = 12'd512;
  localparam logic [11:0] c_ANDI = 12'd768;
  localparam logic [11:0] c_ORI  = 12'd832;
  localparam logic [11:0] c_LW   = 12'd2048;
  localparam logic [11:0] c_SW   = 12'd2560;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    iter_q;
  logic             div_q;
  logic [WIDTH:0]   hi_q;
  logic [WIDTH-1:0] lo_q, b_q;
  logic [WIDTH-1:0] out_q, out_hi_q;
  logic             err_q;

  logic             w_accept, w_long, w_load_1c, w_fin, w_err;
  logic [WIDTH-1:0] w_opb, w_add, w_res, w_lo;
  logic [WIDTH:0]   w_hi, w_sum;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge.
  always_comb begin
    w_long = (cnt == c_MULT) || (cnt == c_DIV);
    w_opb  = (cnt == c_ADD) ? rt : imm;
    w_add  = rs + w_opb;
    w_res  = '0;
    w_err  = 1'b0;
    case (cnt)
      c_ADD, c_ADDI, c_LW, c_SW: w_res = w_add;
      c_SUB:                     w_res = rs - rt;
      c_AND:                     w_res = rs & rt;
      c_OR:                      w_res = rs | rt;
      c_ANDI:                    w_res = rs & imm;
      c_ORI:                     w_res = rs | imm;
      c_MULT, c_DIV:             w_res = '0;
      default:                   w_err = 1'b1;
    endcase
  end

  // One iteration step: shift-add multiply or restoring divide. A zero divisor
  // naturally yields an all-ones quotient and the dividend as remainder.
  always_comb begin
    w_hi  = hi_q;
    w_lo  = lo_q;
    w_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (div_q) begin
        w_hi = {w_hi[WIDTH-1:0], w_lo[WIDTH-1]};
        w_lo = {w_lo[WIDTH-2:0], 1'b0};
        if (w_hi >= {1'b0, b_q}) begin
          w_hi    = w_hi - {1'b0, b_q};
          w_lo[0] = 1'b1;
        end
      end else begin
        w_sum = w_hi + (w_lo[0] ? {1'b0, b_q} : '0);
        w_lo  = {w_sum[0], w_lo[WIDTH-1:1]};
        w_hi  = {1'b0, w_sum[WIDTH:1]};
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    case (state_q)
      S_IDLE: if (in_valid) state_d = w_long ? S_BUSY : S_DONE;
      S_BUSY: if (iter_q == CW'(1)) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = !in_valid ? S_IDLE : (w_long ? S_BUSY : S_DONE);
      default: state_d = S_IDLE;
    endcase
  end

  assign w_accept  = in_valid && in_ready;
  assign w_load_1c = w_accept && !w_long;
  assign w_fin     = (state_q == S_BUSY) && (iter_q == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      out_hi_q <= '0;
      err_q    <= 1'b0;
      iter_q   <= '0;
      div_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      b_q      <= '0;
    end else begin
      state_q <= state_d;
      if (w_accept && w_long) begin
        hi_q   <= '0;
        lo_q   <= rs;
        b_q    <= rt;
        div_q  <= (cnt == c_DIV);
        iter_q <= CW'(ITER);
      end else if (state_q == S_BUSY) begin
        hi_q   <= w_hi;
        lo_q   <= w_lo;
        iter_q <= iter_q - CW'(1);
      end
      if (w_load_1c) begin
        out_q    <= w_res;
        out_hi_q <= '0;
        err_q    <= w_err;
      end else if (w_fin) begin
        out_q    <= w_lo;
        out_hi_q <= w_hi[WIDTH-1:0];
        err_q    <= 1'b0;
      end
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign out       = out_q;
  assign out_hi    = out_hi_q;
  assign err       = err_q;

`ifdef ALU_FLAGS_EN
  logic zero_q, carry_q, ovf_q, w_carry, w_ovf;

  // Carry out of an unsigned add shows up as the sum wrapping below rs.
  always_comb begin
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (cnt)
      c_ADD, c_ADDI, c_LW, c_SW: begin
        w_carry = (w_add < rs);
        w_ovf   = (rs[WIDTH-1] == w_opb[WIDTH-1]) && (w_add[WIDTH-1] != rs[WIDTH-1]);
      end
      c_SUB: begin
        w_carry = (rs < rt);
        w_ovf   = (rs[WIDTH-1] != rt[WIDTH-1]) && (w_res[WIDTH-1] != rs[WIDTH-1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (w_load_1c) begin
      zero_q  <= (w_res == '0);
      carry_q <= w_carry;
      ovf_q   <= w_ovf;
    end else if (w_fin) begin
      zero_q  <= (w_lo == '0);
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end
  end

  assign zero  = zero_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// tb_alu_mc : randomized self-checking bench for alu_mc against a behavioural model.
module tb_alu_mc;
  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, in_ready, out_valid, out_ready, err;
  logic [11:0]   cnt;
  logic [W-1:0]  rs, rt, imm, out, out_hi;
  logic          in_valid4, in_ready4, out_valid4, out_ready4, err4;
  logic [11:0]   cnt4;
  logic [W-1:0]  rs4, rt4, imm4, out4, out_hi4;
`ifdef ALU_FLAGS_EN
  logic zero, carry, ovf, zero4, carry4, ovf4;
`endif

  int errors = 0;
  int checks = 0;
  logic [11:0] ops [11] = '{12'd32, 12'd34, 12'd24, 12'd26, 12'd36, 12'd37,
                            12'd512, 12'd768, 12'd832, 12'd2048, 12'd2560};
  logic [11:0] qc[$];
  logic [31:0] qa[$], qb[$], qi[$];

  alu_mc #(.WIDTH(W), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cnt(cnt),
    .rs(rs), .rt(rt), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .out_hi(out_hi), .err(err)
`ifdef ALU_FLAGS_EN
    , .zero(zero), .carry(carry), .ovf(ovf)
`endif
  );

  alu_mc #(.WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .cnt(cnt4),
    .rs(rs4), .rt(rt4), .imm(imm4), .out_valid(out_valid4), .out_ready(out_ready4),
    .out(out4), .out_hi(out_hi4), .err(err4)
`ifdef ALU_FLAGS_EN
    , .zero(zero4), .carry(carry4), .ovf(ovf4)
`endif
  );

  function automatic void model(input logic [11:0] c, input logic [31:0] a, b, i,
                                output logic [31:0] r, h, output logic e);
    logic [63:0] p;
    r = 32'd0; h = 32'd0; e = 1'b0;
    p = {32'd0, a} * {32'd0, b};
    if (c == 12'd32) r = a + b;
    else if (c == 12'd34) r = a - b;
    else if (c == 12'd36) r = a & b;
    else if (c == 12'd37) r = a | b;
    else if (c == 12'd512 || c == 12'd2048 || c == 12'd2560) r = a + i;
    else if (c == 12'd768) r = a & i;
    else if (c == 12'd832) r = a | i;
    else if (c == 12'd24) begin r = p[31:0]; h = p[63:32]; end
    else if (c == 12'd26) begin
      if (b == 32'd0) begin r = 32'hFFFF_FFFF; h = a; end
      else begin r = a / b; h = a % b; end
    end else e = 1'b1;
  endfunction

  function automatic void flag_model(input logic [11:0] c, input logic [31:0] a, b, i, r,
                                     output logic z, cy, ov);
    logic [32:0] s;
    logic [31:0] op;
    longint      sa;
    z = (r == 32'd0); cy = 1'b0; ov = 1'b0;
    op = (c == 12'd32) ? b : i;
    if (c == 12'd32 || c == 12'd512 || c == 12'd2048 || c == 12'd2560) begin
      s  = {1'b0, a} + {1'b0, op};
      cy = s[32];
      sa = longint'($signed(a)) + longint'($signed(op));
      ov = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    end else if (c == 12'd34) begin
      cy = (a < b);
      sa = longint'($signed(a)) - longint'($signed(b));
      ov = (sa > 64'sd2147483647) || (sa < -64'sd2147483648);
    end
  endfunction

  function automatic logic [11:0] rand_op();
    int k;
    k = $urandom_range(0, 11);
    if (k == 11) return 12'($urandom);
    return ops[k];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    cnt = '0; rs = '0; rt = '0; imm = '0; cnt4 = '0; rs4 = '0; rt4 = '0; imm4 = '0;
    repeat (3) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out !== 32'd0 || out_hi !== 32'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got out=%h hi=%h err=%b exp 0/0/0", out, out_hi, err); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_single(input logic [11:0] c, input logic [31:0] a, b, i);
    logic [31:0] er, eh;
    logic        ee;
    int          lat, exp_lat, busy_bad;
    model(c, a, b, i, er, eh, ee);
    exp_lat = (c == 12'd24 || c == 12'd26) ? W + 1 : 1;
    @(negedge clk);
    cnt = c; rs = a; rt = b; imm = i; in_valid = 1'b1; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_ready cnt=%0d got=%b exp=1", c, in_ready); end
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; cnt = 12'($urandom); rs = $urandom; rt = $urandom; imm = $urandom;
    lat = 1; busy_bad = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) busy_bad++;
      @(negedge clk); lat++;
    end
    checks++; if (lat != exp_lat) begin errors++; $display("FAIL latency cnt=%0d got=%0d exp=%0d", c, lat, exp_lat); end
    checks++; if (busy_bad != 0) begin errors++; $display("FAIL busy_in_ready cnt=%0d got %0d high cycles exp 0", c, busy_bad); end
    checks++; if (out !== er || out_hi !== eh || err !== ee) begin
      errors++; $display("FAIL result cnt=%0d a=%h b=%h i=%h got out=%h hi=%h err=%b exp out=%h hi=%h err=%b",
                         c, a, b, i, out, out_hi, err, er, eh, ee); end
`ifdef ALU_FLAGS_EN
    begin
      logic ez, ecy, eov;
      flag_model(c, a, b, i, er, ez, ecy, eov);
      checks++; if (zero !== ez || carry !== ecy || ovf !== eov) begin
        errors++; $display("FAIL flags cnt=%0d a=%h b=%h got z/c/v=%b%b%b exp %b%b%b", c, a, b, zero, carry, ovf, ez, ecy, eov); end
    end
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_stream();
    logic [31:0] er, eh;
    logic        ee;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < qc.size(); k++) begin
      cnt = qc[k]; rs = qa[k]; rt = qb[k]; imm = qi[k]; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, in_ready); end
      @(posedge clk); @(negedge clk);
      model(qc[k], qa[k], qb[k], qi[k], er, eh, ee);
      checks++; if (out_valid !== 1'b1 || out !== er || out_hi !== eh || err !== ee) begin
        errors++; $display("FAIL b2b k=%0d cnt=%0d got v=%b out=%h hi=%h err=%b exp v=1 out=%h hi=%h err=%b",
                           k, qc[k], out_valid, out, out_hi, err, er, eh, ee); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    qc.delete(); qa.delete(); qb.delete(); qi.delete();
  endtask

  task automatic test_back_to_back();
    qc = '{12'd32, 12'd512, 12'd768, 12'd832};
    qa = '{32'd120, 32'd120, 32'd120, 32'd120};
    qb = '{32'd145, 32'd145, 32'd145, 32'd145};
    qi = '{32'd320, 32'd320, 32'd320, 32'd320};
    run_stream();
    for (int k = 0; k < 20; k++) begin
      logic [11:0] c;
      c = rand_op();
      if (c == 12'd24 || c == 12'd26) c = 12'd37;
      qc.push_back(c); qa.push_back($urandom); qb.push_back($urandom); qi.push_back($urandom);
    end
    run_stream();
  endtask

  task automatic test_stall();
    int bad;
    logic [31:0] er, eh;
    logic        ee;
    @(negedge clk);
    cnt = 12'd32; rs = 32'd120; rt = 32'd145; imm = 32'd0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    cnt = 12'd34; rs = 32'd9; rt = 32'd4;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid !== 1'b1 || out !== 32'd265 || out_hi !== 32'd0 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d unstable cycles exp 0 (out=%h)", bad, out); end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    model(12'd34, 32'd9, 32'd4, 32'd0, er, eh, ee);
    checks++; if (out_valid !== 1'b1 || out !== er) begin
      errors++; $display("FAIL stall_release got v=%b out=%h exp v=1 out=%h", out_valid, out, er); end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    cnt = 12'd24; rs = $urandom | 32'h1000; rt = 32'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || out !== 32'd0 || out_hi !== 32'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midop_reset got v=%b out=%h hi=%h rdy=%b exp 0/0/0/1", out_valid, out, out_hi, in_ready); end
    test_single(12'd24, $urandom, $urandom, 32'd0);
  endtask

  task automatic test_bpc4();
    for (int k = 0; k < 3; k++) begin
      logic [11:0] c;
      logic [31:0] a, b, er, eh;
      logic        ee;
      int          lat;
      c = (k == 1) ? 12'd26 : 12'd24;
      a = (k == 0) ? 32'hFFFF_FFFF : $urandom;
      b = (k == 0) ? 32'd2 : $urandom_range(1, 70000);
      model(c, a, b, 32'd0, er, eh, ee);
      @(negedge clk);
      cnt4 = c; rs4 = a; rt4 = b; imm4 = '0; in_valid4 = 1'b1; out_ready4 = 1'b0;
      @(posedge clk); @(negedge clk);
      in_valid4 = 1'b0; rs4 = $urandom; rt4 = $urandom;
      lat = 1;
      while (out_valid4 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      checks++; if (lat != 9 || out4 !== er || out_hi4 !== eh || err4 !== 1'b0) begin
        errors++; $display("FAIL bpc4 cnt=%0d got lat=%0d out=%h hi=%h err=%b exp lat=9 out=%h hi=%h err=0",
                           c, lat, out4, out_hi4, err4, er, eh); end
      out_ready4 = 1'b1;
      @(negedge clk);
      out_ready4 = 1'b0;
    end
  endtask

  task automatic test_directed();
    test_single(12'd24, 32'hFFFF_FFFF, 32'd2, 32'd0);
    test_single(12'd26, 32'd145, 32'd12, 32'd0);
    test_single(12'd26, 32'd145, 32'd0, 32'd0);
    test_single(12'd0, 32'd77, 32'd5, 32'd9);
    test_single(12'd34, 32'd5, 32'd5, 32'd0);
    test_single(12'd32, 32'h7FFF_FFFF, 32'd1, 32'd0);
    test_single(12'd32, 32'hFFFF_FFFF, 32'd1, 32'd0);
    test_single(12'd34, 32'd3, 32'd5, 32'd0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) test_single(rand_op(), $urandom, $urandom, $urandom);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_directed();
    test_stall();
    test_reset_midop();
    test_bpc4();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
